// File: rtl/wb_stage.sv
// RISC-V write-back stage: retires ALU results in one cycle, waits on data memory for loads.
// Optional retire counter port retire_cnt_o is enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_wb_i,
    input  logic                  RegWrite_wb_i,
    input  logic                  MemRead_wb_i,
    input  logic [REG_ADDR_W-1:0] Rd_wb_i,
    input  logic [2:0]            func3_wb_i,
    input  logic [1:0]            addr_lo_wb_i,
    input  logic [XLEN-1:0]       alu_result_wb_i,
    input  logic                  mem_rvalid_i,
    input  logic [XLEN-1:0]       mem_rdata_i,
    output logic                  stall_wb_o,
    output logic [REG_ADDR_W-1:0] Rd_wb_o,
    output logic                  RegWrite_wb_o,
`ifdef WB_RETIRE_CNT_EN
    output logic [XLEN-1:0]       Wr_reg_data_wb_o,
    output logic [63:0]           retire_cnt_o
`else
    output logic [XLEN-1:0]       Wr_reg_data_wb_o
`endif
);

    typedef enum logic {ST_IDLE, ST_WAIT_LOAD} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_accept;
    logic                  w_load_done;
    logic [XLEN-1:0]       w_load_data;

    logic [REG_ADDR_W-1:0] r_rd_p1;
    logic                  r_rw_p1;
    logic [2:0]            r_f3_p1;
    logic [1:0]            r_lo_p1;

    logic [REG_ADDR_W-1:0] r_rd_p2;
    logic                  r_we_p2;
    logic [XLEN-1:0]       r_data_p2;

    // Byte/half selection from the aligned word; misaligned halves ignore addr_lo[0].
    function automatic logic [XLEN-1:0] f_extract(input logic [XLEN-1:0] word,
                                                  input logic [2:0]      f3,
                                                  input logic [1:0]      lo);
        logic [XLEN-1:0]        shifted;
        logic signed [7:0]      sbyte;
        logic signed [15:0]     shalf;
        logic signed [XLEN-1:0] sext;
        logic [XLEN-1:0]        res;
        shifted = word >> {lo, 3'b000};
        sbyte   = shifted[7:0];
        shalf   = lo[1] ? word[31:16] : word[15:0];
        res     = word;
        case (f3)
            3'b000: begin sext = sbyte; res = sext; end
            3'b001: begin sext = shalf; res = sext; end
            3'b100: res = {24'd0, sbyte};
            3'b101: res = {16'd0, shalf};
            default: res = word;
        endcase
        return res;
    endfunction

    assign stall_wb_o  = (r_state == ST_WAIT_LOAD);
    assign w_accept    = valid_wb_i && !stall_wb_o;
    assign w_load_done = (r_state == ST_WAIT_LOAD) && mem_rvalid_i;
    assign w_load_data = f_extract(mem_rdata_i, r_f3_p1, r_lo_p1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (w_accept && MemRead_wb_i) w_state_nxt = ST_WAIT_LOAD;
            ST_WAIT_LOAD: if (mem_rvalid_i) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // p1: load fields held while the memory response is outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_p1 <= '0;
            r_rw_p1 <= 1'b0;
            r_f3_p1 <= '0;
            r_lo_p1 <= '0;
        end else if (w_accept && MemRead_wb_i) begin
            r_rd_p1 <= Rd_wb_i;
            r_rw_p1 <= RegWrite_wb_i;
            r_f3_p1 <= func3_wb_i;
            r_lo_p1 <= addr_lo_wb_i;
        end
    end

    // p2: register-file write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_p2   <= '0;
            r_we_p2   <= 1'b0;
            r_data_p2 <= '0;
        end else begin
            r_we_p2 <= 1'b0;
            if (w_load_done) begin
                r_we_p2   <= r_rw_p1 && (r_rd_p1 != '0);
                r_rd_p2   <= r_rd_p1;
                r_data_p2 <= w_load_data;
            end else if (w_accept && !MemRead_wb_i) begin
                r_we_p2   <= RegWrite_wb_i && (Rd_wb_i != '0);
                r_rd_p2   <= Rd_wb_i;
                r_data_p2 <= alu_result_wb_i;
            end
        end
    end

    assign Rd_wb_o          = r_rd_p2;
    assign RegWrite_wb_o    = r_we_p2;
    assign Wr_reg_data_wb_o = r_data_p2;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          r_cnt <= '0;
        else if (w_load_done || (w_accept && !MemRead_wb_i)) r_cnt <= r_cnt + 64'd1;
    end
    assign retire_cnt_o = r_cnt;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed ALU/load vectors, expected writes queued by stimulus.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_wb_i, RegWrite_wb_i, MemRead_wb_i;
    logic [4:0]  Rd_wb_i;
    logic [2:0]  func3_wb_i;
    logic [1:0]  addr_lo_wb_i;
    logic [31:0] alu_result_wb_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        stall_wb_o;
    logic [4:0]  Rd_wb_o;
    logic        RegWrite_wb_o;
    logic [31:0] Wr_reg_data_wb_o;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_o;
`endif

    wb_stage dut (
        .clk(clk), .rst_n(rst_n),
        .valid_wb_i(valid_wb_i), .RegWrite_wb_i(RegWrite_wb_i), .MemRead_wb_i(MemRead_wb_i),
        .Rd_wb_i(Rd_wb_i), .func3_wb_i(func3_wb_i), .addr_lo_wb_i(addr_lo_wb_i),
        .alu_result_wb_i(alu_result_wb_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .stall_wb_o(stall_wb_o), .Rd_wb_o(Rd_wb_o), .RegWrite_wb_o(RegWrite_wb_o),
`ifdef WB_RETIRE_CNT_EN
        .Wr_reg_data_wb_o(Wr_reg_data_wb_o),
        .retire_cnt_o(retire_cnt_o)
`else
        .Wr_reg_data_wb_o(Wr_reg_data_wb_o)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [36:0] exp_q[$];
    longint      exp_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic chk_cnt(input string name);
`ifdef WB_RETIRE_CNT_EN
        chk(name, retire_cnt_o, exp_cnt);
`endif
    endtask

    // Monitor: every write-port pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (RegWrite_wb_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got rd=%0d data=%h, required no write",
                         Rd_wb_o, Wr_reg_data_wb_o);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("write_rd_data", {27'd0, Rd_wb_o, Wr_reg_data_wb_o}, {27'd0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic rw, input logic [31:0] data);
        valid_wb_i = 1'b1; MemRead_wb_i = 1'b0; RegWrite_wb_i = rw;
        Rd_wb_i = rd; alu_result_wb_i = data;
        if (rw && rd != 5'd0) exp_q.push_back({rd, data});
        exp_cnt++;
        tick();
        valid_wb_i = 1'b0;
    endtask

    // Load with lat cycles to response; optionally hold a non-load valid during the wait.
    task automatic load_op(input logic [4:0] rd, input logic rw, input logic [2:0] f3,
                           input logic [1:0] lo, input int lat, input logic [31:0] rdata,
                           input logic [31:0] expd, input logic hold, input logic [31:0] hdata);
        valid_wb_i = 1'b1; MemRead_wb_i = 1'b1; RegWrite_wb_i = rw;
        Rd_wb_i = rd; func3_wb_i = f3; addr_lo_wb_i = lo; alu_result_wb_i = 32'h0BAD_0BAD;
        tick();
        valid_wb_i = hold; MemRead_wb_i = 1'b0; RegWrite_wb_i = 1'b1;
        Rd_wb_i = 5'd20; alu_result_wb_i = hdata; func3_wb_i = 3'b000; addr_lo_wb_i = 2'b00;
        for (int i = 0; i < lat; i++) begin
            chk("stall_during_wait", {63'd0, stall_wb_o}, 64'd1);
            chk("no_write_during_wait", {63'd0, RegWrite_wb_o}, 64'd0);
            if (i == lat - 1) begin
                mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
                if (rw && rd != 5'd0) exp_q.push_back({rd, expd});
                exp_cnt++;
            end else begin
                mem_rdata_i = ~rdata;
            end
            tick();
        end
        mem_rvalid_i = 1'b0;
        chk("stall_after_resp", {63'd0, stall_wb_o}, 64'd0);
        if (hold) begin
            exp_q.push_back({5'd20, hdata});
            exp_cnt++;
            tick();
            valid_wb_i = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; valid_wb_i = 1'b0; RegWrite_wb_i = 1'b0; MemRead_wb_i = 1'b0;
        Rd_wb_i = '0; func3_wb_i = '0; addr_lo_wb_i = '0; alu_result_wb_i = '0;
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        repeat (3) tick();
        chk("reset_stall", {63'd0, stall_wb_o}, 64'd0);
        chk("reset_we", {63'd0, RegWrite_wb_o}, 64'd0);
        chk("reset_rd", {59'd0, Rd_wb_o}, 64'd0);
        chk("reset_data", {32'd0, Wr_reg_data_wb_o}, 64'd0);
        chk_cnt("reset_cnt");
        rst_n = 1'b1;
        tick();

        // Retire-count scenario: 2 ALU, 1 load latency 1, 1 Rd=0 op.
        alu_op(5'd5, 1'b1, 32'h1234_5678);
        chk("add_pulse_rd5", {32'd0, Wr_reg_data_wb_o}, 64'h1234_5678);
        tick();
        chk("add_pulse_end", {63'd0, RegWrite_wb_o}, 64'd0);
        alu_op(5'd6, 1'b1, 32'hCAFE_F00D);
        load_op(5'd8, 1'b1, 3'b010, 2'b00, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'd0);
        alu_op(5'd0, 1'b1, 32'hFFFF_FFFF);
        tick();
        chk("x0_no_write", {63'd0, RegWrite_wb_o}, 64'd0);
        chk_cnt("cnt_four");

        // Load scenarios with directed data.
        load_op(5'd7, 1'b1, 3'b000, 2'd3, 3, 32'h80AB_CD12, 32'hFFFF_FF80, 1'b0, 32'd0);
        load_op(5'd9, 1'b1, 3'b101, 2'd2, 2, 32'h9ABC_1234, 32'h0000_9ABC, 1'b0, 32'd0);
        load_op(5'd10, 1'b1, 3'b001, 2'd2, 1, 32'h9ABC_1234, 32'hFFFF_9ABC, 1'b0, 32'd0);
        load_op(5'd11, 1'b1, 3'b100, 2'd1, 2, 32'h0000_F100, 32'h0000_00F1, 1'b0, 32'd0);
        load_op(5'd12, 1'b1, 3'b000, 2'd1, 1, 32'h0000_F100, 32'hFFFF_FFF1, 1'b0, 32'd0);
        load_op(5'd13, 1'b1, 3'b001, 2'd3, 2, 32'h8001_0000, 32'hFFFF_8001, 1'b0, 32'd0);
        load_op(5'd14, 1'b1, 3'b001, 2'd1, 1, 32'h0000_7FFE, 32'h0000_7FFE, 1'b0, 32'd0);
        load_op(5'd15, 1'b1, 3'b110, 2'd1, 1, 32'h1234_ABCD, 32'h1234_ABCD, 1'b0, 32'd0);
        load_op(5'd0, 1'b1, 3'b010, 2'd0, 2, 32'h5555_5555, 32'h5555_5555, 1'b0, 32'd0);
        load_op(5'd16, 1'b0, 3'b010, 2'd0, 1, 32'h6666_6666, 32'h6666_6666, 1'b0, 32'd0);
        // Upstream holds valid during the wait; it retires once, right after the response.
        load_op(5'd17, 1'b1, 3'b100, 2'd3, 3, 32'hA500_0000, 32'h0000_00A5, 1'b1, 32'h0777_0777);
        alu_op(5'd18, 1'b1, 32'h0000_0001);
        alu_op(5'd19, 1'b1, 32'h8000_0000);

        // Response in IDLE must be ignored.
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_1111;
        tick();
        mem_rvalid_i = 1'b0;
        chk("idle_rvalid_stall", {63'd0, stall_wb_o}, 64'd0);
        tick();
        chk_cnt("cnt_total");

        // Reset while a load is outstanding.
        valid_wb_i = 1'b1; MemRead_wb_i = 1'b1; RegWrite_wb_i = 1'b1;
        Rd_wb_i = 5'd21; func3_wb_i = 3'b010; addr_lo_wb_i = 2'd0;
        tick();
        valid_wb_i = 1'b0; MemRead_wb_i = 1'b0;
        chk("midload_stall", {63'd0, stall_wb_o}, 64'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_rst_stall", {63'd0, stall_wb_o}, 64'd0);
        chk("async_rst_rd", {59'd0, Rd_wb_o}, 64'd0);
        chk("async_rst_data", {32'd0, Wr_reg_data_wb_o}, 64'd0);
        exp_cnt = 0;
        chk_cnt("async_rst_cnt");
        tick();
        rst_n = 1'b1;
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h2222_2222;
        tick();
        mem_rvalid_i = 1'b0;
        chk("post_rst_stall", {63'd0, stall_wb_o}, 64'd0);
        tick();
        alu_op(5'd22, 1'b1, 32'h00C0_FFEE);
        tick();
        chk_cnt("post_rst_cnt");
        tick();
        chk("scoreboard_drained", {32'd0, 32'(exp_q.size())}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
